// File: rtl/drive_mode_fsm.sv
// Drive-path mode controller: IR-decoded IDLE/CAM/IR modes, camera tracking
// sub-FSM with lost-target hold and timed search sweep, manual IR drive with watchdog.
module drive_mode_fsm #(
  parameter int unsigned SPEED_W      = 2,
  parameter int unsigned LOST_TIMEOUT = 25000000,
  parameter int unsigned SWEEP_CYCLES = 100000000,
  parameter int unsigned IR_TIMEOUT   = 12500000,
  parameter logic [7:0]  CODE_CAM     = 8'h0F,
  parameter logic [7:0]  CODE_IR      = 8'h13,
  parameter logic [7:0]  CODE_IDLE    = 8'h10,
  parameter logic [7:0]  CODE_FWD     = 8'h18,
  parameter logic [7:0]  CODE_LEFT    = 8'h08,
  parameter logic [7:0]  CODE_RIGHT   = 8'h5A,
  parameter logic [7:0]  CODE_STOP    = 8'h1C,
  parameter logic [7:0]  CODE_SPDUP   = 8'h40,
  parameter logic [7:0]  CODE_SPDDN   = 8'h19
) (
  input  logic               clk_50,
  input  logic               reset,
  input  logic               ir_valid,
  input  logic [7:0]         ir_code,
  input  logic               target_detected,
  input  logic [1:0]         cam_direction,
  input  logic [SPEED_W-1:0] cam_speed,
  output logic [1:0]         mode,
  output logic [1:0]         cam_state,
  output logic [2:0]         drive_cmd,
  output logic [SPEED_W-1:0] drive_speed,
  output logic               search_dir,
  output logic               mode_change
);

  typedef enum logic [1:0] {
    MODE_IDLE = 2'b00,
    MODE_CAM  = 2'b01,
    MODE_IR   = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    CAM_SEARCH = 2'b00,
    CAM_FOLLOW = 2'b01,
    CAM_LOST   = 2'b10,
    CAM_PAUSE  = 2'b11
  } cam_e;

  typedef enum logic [2:0] {
    CMD_STOP  = 3'b000,
    CMD_LEFT  = 3'b001,
    CMD_RIGHT = 3'b010,
    CMD_FWD   = 3'b011
  } cmd_e;

  localparam int unsigned LOST_W  = (LOST_TIMEOUT > 1) ? $clog2(LOST_TIMEOUT) : 1;
  localparam int unsigned SWEEP_W = (SWEEP_CYCLES > 1) ? $clog2(SWEEP_CYCLES) : 1;
  localparam int unsigned IR_W    = (IR_TIMEOUT > 1)   ? $clog2(IR_TIMEOUT)   : 1;

  localparam logic [LOST_W-1:0]  LOST_LAST  = LOST_W'(LOST_TIMEOUT - 1);
  localparam logic [SWEEP_W-1:0] SWEEP_LAST = SWEEP_W'(SWEEP_CYCLES - 1);
  localparam logic [IR_W-1:0]    IR_LAST    = IR_W'(IR_TIMEOUT - 1);
  localparam logic [SPEED_W-1:0] SPD_MAX    = {SPEED_W{1'b1}};

  mode_e               mode_q, mode_d;
  cam_e                cam_q, cam_d;
  cmd_e                drive_cmd_q, drive_cmd_d;
  logic [SPEED_W-1:0]  drive_speed_q, drive_speed_d;
  logic                search_dir_q, search_dir_d;
  logic                mode_change_q, mode_change_d;
  cmd_e                man_cmd_q, man_cmd_d;
  logic [SPEED_W-1:0]  man_speed_q, man_speed_d;
  logic [1:0]          last_dir_q, last_dir_d;
  logic [LOST_W-1:0]   lost_cnt_q, lost_cnt_d;
  logic [SWEEP_W-1:0]  sweep_cnt_q, sweep_cnt_d;
  logic [IR_W-1:0]     wd_cnt_q, wd_cnt_d;

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      mode_q        <= MODE_IDLE;
      cam_q         <= CAM_PAUSE;
      drive_cmd_q   <= CMD_STOP;
      drive_speed_q <= '0;
      search_dir_q  <= 1'b1;
      mode_change_q <= 1'b0;
      man_cmd_q     <= CMD_STOP;
      man_speed_q   <= '0;
      last_dir_q    <= 2'b00;
      lost_cnt_q    <= '0;
      sweep_cnt_q   <= '0;
      wd_cnt_q      <= '0;
    end else begin
      mode_q        <= mode_d;
      cam_q         <= cam_d;
      drive_cmd_q   <= drive_cmd_d;
      drive_speed_q <= drive_speed_d;
      search_dir_q  <= search_dir_d;
      mode_change_q <= mode_change_d;
      man_cmd_q     <= man_cmd_d;
      man_speed_q   <= man_speed_d;
      last_dir_q    <= last_dir_d;
      lost_cnt_q    <= lost_cnt_d;
      sweep_cnt_q   <= sweep_cnt_d;
      wd_cnt_q      <= wd_cnt_d;
    end
  end

  always_comb begin
    mode_d        = mode_q;
    cam_d         = cam_q;
    drive_cmd_d   = CMD_STOP;
    drive_speed_d = '0;
    search_dir_d  = search_dir_q;
    man_cmd_d     = man_cmd_q;
    man_speed_d   = man_speed_q;
    last_dir_d    = last_dir_q;
    lost_cnt_d    = '0;
    sweep_cnt_d   = '0;
    wd_cnt_d      = '0;

    if (ir_valid) begin
      case (ir_code)
        CODE_CAM:  mode_d = MODE_CAM;
        CODE_IR:   mode_d = MODE_IR;
        CODE_IDLE: mode_d = MODE_IDLE;
        default:   ;
      endcase
    end

    // A mode command always overrides the target-driven transitions.
    if (mode_d != MODE_CAM) begin
      cam_d = CAM_PAUSE;
    end else if (mode_q != MODE_CAM) begin
      cam_d = CAM_SEARCH;
    end else begin
      case (cam_q)
        CAM_SEARCH: if (target_detected) cam_d = CAM_FOLLOW;
        CAM_FOLLOW: if (!target_detected) cam_d = CAM_LOST;
        CAM_LOST: begin
          if (target_detected) cam_d = CAM_FOLLOW;
          else if (lost_cnt_q == LOST_LAST) cam_d = CAM_SEARCH;
        end
        default: cam_d = CAM_SEARCH;
      endcase
    end

    if (cam_q == CAM_FOLLOW && cam_direction != 2'b00) last_dir_d = cam_direction;

    if (cam_q == CAM_LOST && cam_d == CAM_LOST) lost_cnt_d = lost_cnt_q + LOST_W'(1);

    if (cam_q == CAM_SEARCH && cam_d == CAM_SEARCH) begin
      if (sweep_cnt_q == SWEEP_LAST) search_dir_d = ~search_dir_q;
      else sweep_cnt_d = sweep_cnt_q + SWEEP_W'(1);
    end

    // Resume the sweep toward the side the target was last seen on.
    if (cam_q == CAM_LOST && cam_d == CAM_SEARCH) begin
      if (last_dir_q == 2'b01) search_dir_d = 1'b0;
      else if (last_dir_q == 2'b10) search_dir_d = 1'b1;
    end

    if (mode_d == MODE_IR && mode_q != MODE_IR) begin
      man_cmd_d = CMD_STOP;
    end else if (mode_d == MODE_IR) begin
      if (ir_valid) begin
        case (ir_code)
          CODE_FWD:   man_cmd_d = CMD_FWD;
          CODE_LEFT:  man_cmd_d = CMD_LEFT;
          CODE_RIGHT: man_cmd_d = CMD_RIGHT;
          CODE_STOP:  man_cmd_d = CMD_STOP;
          CODE_SPDUP: if (man_speed_q != SPD_MAX) man_speed_d = man_speed_q + SPEED_W'(1);
          CODE_SPDDN: if (man_speed_q != '0) man_speed_d = man_speed_q - SPEED_W'(1);
          default:    ;
        endcase
      end else if (wd_cnt_q == IR_LAST) begin
        man_cmd_d = CMD_STOP;
        wd_cnt_d  = wd_cnt_q;
      end else begin
        wd_cnt_d = wd_cnt_q + IR_W'(1);
      end
    end

    case (mode_d)
      MODE_CAM: begin
        if (cam_d == CAM_SEARCH) begin
          drive_cmd_d = search_dir_d ? CMD_RIGHT : CMD_LEFT;
        end else if (cam_d == CAM_FOLLOW) begin
          case (cam_direction)
            2'b01:   drive_cmd_d = CMD_LEFT;
            2'b10:   drive_cmd_d = CMD_RIGHT;
            2'b11:   drive_cmd_d = CMD_FWD;
            default: drive_cmd_d = CMD_STOP;
          endcase
          if (cam_direction != 2'b00) drive_speed_d = cam_speed;
        end
      end
      MODE_IR: begin
        drive_cmd_d = man_cmd_d;
        if (man_cmd_d != CMD_STOP) drive_speed_d = man_speed_d;
      end
      default: ;
    endcase

    mode_change_d = (mode_d != mode_q) || (cam_d != cam_q);
  end

  assign mode        = mode_q;
  assign cam_state   = cam_q;
  assign drive_cmd   = drive_cmd_q;
  assign drive_speed = drive_speed_q;
  assign search_dir  = search_dir_q;
  assign mode_change = mode_change_q;

endmodule

// File: tb/tb_drive_mode_fsm.sv
// Scoreboard bench for drive_mode_fsm: directed scenarios plus random IR/camera
// traffic, checked against an age-counting reference model.
module tb_drive_mode_fsm;

  localparam int SPEED_W = 2;
  localparam int LOST_T  = 5;
  localparam int SWEEP   = 8;
  localparam int IR_T    = 10;
  localparam int MAXSPD  = (1 << SPEED_W) - 1;

  localparam logic [7:0] C_CAM = 8'h0F, C_IR = 8'h13, C_IDLE = 8'h10;
  localparam logic [7:0] C_FWD = 8'h18, C_LEFT = 8'h08, C_RIGHT = 8'h5A, C_STOP = 8'h1C;
  localparam logic [7:0] C_UP = 8'h40, C_DN = 8'h19;

  logic               clk_50 = 1'b0;
  logic               reset = 1'b0;
  logic               ir_valid = 1'b0;
  logic [7:0]         ir_code = 8'h00;
  logic               target_detected = 1'b0;
  logic [1:0]         cam_direction = 2'b00;
  logic [SPEED_W-1:0] cam_speed = '0;
  logic [1:0]         mode;
  logic [1:0]         cam_state;
  logic [2:0]         drive_cmd;
  logic [SPEED_W-1:0] drive_speed;
  logic               search_dir;
  logic               mode_change;

  drive_mode_fsm #(
    .SPEED_W(SPEED_W), .LOST_TIMEOUT(LOST_T), .SWEEP_CYCLES(SWEEP), .IR_TIMEOUT(IR_T)
  ) dut (
    .clk_50(clk_50), .reset(reset), .ir_valid(ir_valid), .ir_code(ir_code),
    .target_detected(target_detected), .cam_direction(cam_direction), .cam_speed(cam_speed),
    .mode(mode), .cam_state(cam_state), .drive_cmd(drive_cmd), .drive_speed(drive_speed),
    .search_dir(search_dir), .mode_change(mode_change)
  );

  always #10 clk_50 = ~clk_50;

  typedef struct {
    int mode; int cam; int cmd; int spd; int sdir; int mc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int n_checks = 0;
  int n_fail = 0;

  // Reference model state. Modes: 0 idle, 1 cam, 2 ir. Camera: 0 search, 1 follow,
  // 2 lost, 3 pause. m_last: -1 no steering hint, 0 left, 1 right.
  int m_mode, m_cam, m_dir, m_last, m_lost_age, m_sweep_age, m_idle, m_mspeed, m_mcmd;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cam = 3; m_dir = 1; m_last = -1;
    m_lost_age = 0; m_sweep_age = 0; m_idle = 0; m_mspeed = 0; m_mcmd = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] code, input bit tgt,
                            input int dir, input int spd);
    int pm, pc, nm, nc;
    exp_t e;
    pm = m_mode; pc = m_cam; nm = pm;
    if (v) begin
      if (code == C_CAM) nm = 1;
      else if (code == C_IR) nm = 2;
      else if (code == C_IDLE) nm = 0;
    end
    if (nm != 1) nc = 3;
    else if (pm != 1) nc = 0;
    else if (pc == 0) nc = tgt ? 1 : 0;
    else if (pc == 1) nc = tgt ? 1 : 2;
    else if (pc == 2) nc = tgt ? 1 : ((m_lost_age + 1 >= LOST_T) ? 0 : 2);
    else nc = 0;

    if (pc == 1) begin
      if (dir == 1) m_last = 0;
      else if (dir == 2) m_last = 1;
      else if (dir == 3) m_last = -1;
    end
    if (pc == 2 && nc == 0 && m_last >= 0) m_dir = m_last;
    if (pc == 0 && nc == 0) begin
      m_sweep_age++;
      if (m_sweep_age == SWEEP) begin
        m_dir = 1 - m_dir;
        m_sweep_age = 0;
      end
    end else m_sweep_age = 0;
    m_lost_age = (pc == 2 && nc == 2) ? m_lost_age + 1 : 0;

    if (nm == 2 && pm != 2) begin
      m_mcmd = 0; m_idle = 0;
    end else if (nm == 2) begin
      if (v) begin
        m_idle = 0;
        if (code == C_FWD) m_mcmd = 3;
        else if (code == C_LEFT) m_mcmd = 1;
        else if (code == C_RIGHT) m_mcmd = 2;
        else if (code == C_STOP) m_mcmd = 0;
        else if (code == C_UP && m_mspeed < MAXSPD) m_mspeed++;
        else if (code == C_DN && m_mspeed > 0) m_mspeed--;
      end else begin
        m_idle++;
        if (m_idle >= IR_T) m_mcmd = 0;
      end
    end

    e.cmd = 0; e.spd = 0;
    if (nm == 1 && nc == 0) e.cmd = m_dir ? 2 : 1;
    else if (nm == 1 && nc == 1) begin
      e.cmd = (dir == 1) ? 1 : (dir == 2) ? 2 : (dir == 3) ? 3 : 0;
      e.spd = (e.cmd == 0) ? 0 : spd;
    end else if (nm == 2) begin
      e.cmd = m_mcmd;
      e.spd = (m_mcmd == 0) ? 0 : m_mspeed;
    end
    e.mode = nm; e.cam = nc; e.sdir = m_dir;
    e.mc = (nm != pm || nc != pc) ? 1 : 0;
    m_mode = nm; m_cam = nc;
    sb.push_back(e);
  endtask

  // Starts and ends on a falling edge; the rising edge in between consumes the inputs.
  task automatic cycle(input bit v, input logic [7:0] code, input bit tgt,
                       input int dir, input int spd);
    ir_valid = v; ir_code = code; target_detected = tgt;
    cam_direction = 2'(dir); cam_speed = SPEED_W'(spd);
    model_step(v, code, tgt, dir, spd);
    @(negedge clk_50);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mode"}, mode, 0);
    check({tag, "_cam"}, cam_state, 3);
    check({tag, "_cmd"}, drive_cmd, 0);
    check({tag, "_spd"}, drive_speed, 0);
    check({tag, "_sdir"}, search_dir, 1);
    check({tag, "_mc"}, mode_change, 0);
  endtask

  always @(posedge clk_50) begin
    #1;
    if (!reset && sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("mode", mode, mon_e.mode);
      check("cam_state", cam_state, mon_e.cam);
      check("drive_cmd", drive_cmd, mon_e.cmd);
      check("drive_speed", drive_speed, mon_e.spd);
      check("search_dir", search_dir, mon_e.sdir);
      check("mode_change", mode_change, mon_e.mc);
    end
  end

  initial begin
    logic [7:0] codes [12];
    bit tgt;
    int dir, spd;
    codes = '{C_CAM, C_IR, C_IDLE, C_FWD, C_LEFT, C_RIGHT, C_STOP, C_UP, C_DN, C_UP, C_DN, 8'hA5};

    #2 reset = 1'b1;
    #1 check_reset_values("por");
    model_reset();
    @(negedge clk_50);
    @(negedge clk_50);
    reset = 1'b0;

    // Enter CAM, then sweep with no target for several half-periods.
    cycle(1, C_CAM, 0, 0, 0);
    repeat (20) cycle(0, 8'h00, 0, 0, 0);

    // Follow forward, lose the target heading left, time out into search.
    repeat (4) cycle(0, 8'h00, 1, 3, 2);
    cycle(0, 8'h00, 0, 1, 2);
    repeat (7) cycle(0, 8'h00, 0, 0, 0);
    repeat (3) cycle(0, 8'h00, 1, 2, 1);
    repeat (3) cycle(0, 8'h00, 0, 0, 0);
    repeat (2) cycle(0, 8'h00, 1, 1, 3);

    // Mode command beats a simultaneous target, then switch to IR.
    cycle(1, C_IDLE, 0, 0, 0);
    cycle(1, C_CAM, 1, 3, 2);
    repeat (2) cycle(0, 8'h00, 1, 3, 2);
    cycle(1, C_IR, 1, 3, 2);

    // Speed saturation both ways, then the command watchdog.
    repeat (5) begin
      cycle(1, C_UP, 0, 0, 0);
      cycle(0, 8'h00, 0, 0, 0);
    end
    cycle(1, C_FWD, 0, 0, 0);
    repeat (14) cycle(0, 8'h00, 0, 0, 0);
    cycle(1, C_LEFT, 0, 0, 0);
    repeat (5) cycle(1, C_DN, 0, 0, 0);
    cycle(1, C_RIGHT, 0, 0, 0);
    cycle(1, C_UP, 0, 0, 0);
    cycle(1, C_IR, 0, 0, 0);

    tgt = 0; dir = 0; spd = 0;
    repeat (3000) begin
      if ($urandom_range(0, 5) == 0) tgt = ~tgt;
      if ($urandom_range(0, 3) == 0) dir = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) spd = $urandom_range(0, MAXSPD);
      if ($urandom_range(0, 5) == 0) cycle(1, codes[$urandom_range(0, 11)], tgt, dir, spd);
      else cycle(0, 8'($urandom_range(0, 255)), tgt, dir, spd);
    end

    // Asynchronous reset in the middle of FOLLOW.
    cycle(1, C_CAM, 0, 0, 0);
    repeat (3) cycle(0, 8'h00, 1, 3, 3);
    #5 reset = 1'b1;
    #1 check_reset_values("async");
    sb.delete();
    model_reset();
    @(negedge clk_50);
    reset = 1'b0;
    cycle(1, C_CAM, 1, 2, 1);
    repeat (3) cycle(0, 8'h00, 1, 2, 1);

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk_50);
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/drive_mode_fsm.md
Name: drive_mode_fsm

Overview:
Parametrised top-level mode controller for the robot drive path. It decodes IR remote commands into IDLE / CAM / IR modes and runs a camera target-tracking sub-FSM with a lost-target hold and a timed alternating search sweep. It also runs a manual IR drive mode with speed stepping and a command watchdog. It emits a registered drive command plus speed to the motor block and a one-cycle mode-change pulse that downstream blocks use for soft reset.

Parameters:
SPEED_W, 2, width of speed fields; the speed range is 0 .. 2**SPEED_W-1.
LOST_TIMEOUT, 25000000, cycles without a target in LOST before falling back to SEARCH (0.5 s at 50 MHz); must be >= 1.
SWEEP_CYCLES, 100000000, cycles per search sweep before search_dir flips; must be >= 1.
IR_TIMEOUT, 12500000, cycles without ir_valid in IR mode before the manual command is forced to STOP; must be >= 1.
CODE_CAM, 8'h0F, IR code: enter CAM mode.
CODE_IR, 8'h13, IR code: enter IR mode.
CODE_IDLE, 8'h10, IR code: enter IDLE mode.
CODE_FWD, 8'h18, IR code: manual forward.
CODE_LEFT, 8'h08, IR code: manual left.
CODE_RIGHT, 8'h5A, IR code: manual right.
CODE_STOP, 8'h1C, IR code: manual stop.
CODE_SPDUP, 8'h40, IR code: manual speed +1.
CODE_SPDDN, 8'h19, IR code: manual speed -1.

Ports:
clk_50  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high reset
ir_valid  in  1  one-cycle strobe; ir_code is valid in this cycle
ir_code  in  8  decoded IR button code
target_detected  in  1  camera reports a target in the current frame (level)
cam_direction  in  2  00 none, 01 left, 10 right, 11 centre
cam_speed  in  SPEED_W  camera-requested speed (distance based)
mode  out  2  00 IDLE, 01 CAM, 10 IR
cam_state  out  2  00 SEARCH, 01 FOLLOW, 10 LOST, 11 PAUSE
drive_cmd  out  3  000 STOP, 001 LEFT, 010 RIGHT, 011 FWD
drive_speed  out  SPEED_W  speed for drive_cmd
search_dir  out  1  1 = sweep right, 0 = sweep left
mode_change  out  1  one-cycle pulse when mode or cam_state changes

Behaviour:
- All outputs are registered. Each output reflects its inputs with exactly 1 cycle of latency.
- Reset values (asynchronous): mode IDLE, cam_state PAUSE, drive_cmd STOP, drive_speed 0, search_dir 1, manual speed 0, manual cmd STOP, all counters 0, mode_change 0.
- IR codes are acted on only when ir_valid=1. Unknown codes are ignored.
- Mode transitions:
  - CODE_CAM goes to CAM, CODE_IR goes to IR, CODE_IDLE goes to IDLE, from any mode.
  - A code naming the current mode causes no transition and no pulse.
- cam_state:
  - Entering CAM forces SEARCH, even if target_detected=1 in the same cycle; a mode command always beats target input.
  - Leaving CAM forces PAUSE.
  - SEARCH to FOLLOW when target_detected=1.
  - FOLLOW to LOST when target_detected=0; the lost counter clears to 0.
  - LOST to FOLLOW when target_detected=1; the counter clears.
  - LOST to SEARCH when the counter reaches LOST_TIMEOUT-1. On this transition search_dir is set from the last non-zero cam_direction seen in FOLLOW (01 gives 0, 10 gives 1); it is unchanged if that direction was centre or none.
- Sweep counter:
  - Runs only in SEARCH and clears on SEARCH entry.
  - At SWEEP_CYCLES-1 it toggles search_dir and wraps to 0.
- Drive output by state:
  - IDLE, PAUSE and LOST give STOP with speed 0.
  - SEARCH gives RIGHT if search_dir=1, else LEFT, with speed 0.
  - FOLLOW: cam_direction 01 gives LEFT, 10 gives RIGHT, 11 gives FWD, 00 gives STOP. drive_speed = cam_speed, or 0 when STOP.
- IR mode:
  - FWD, LEFT, RIGHT and STOP codes load the manual cmd.
  - SPDUP and SPDDN step the manual speed, saturating at 2**SPEED_W-1 and at 0. The manual speed persists across modes and clears only on reset.
  - The watchdog counter clears on every ir_valid while in IR mode. At IR_TIMEOUT-1 the manual cmd is forced to STOP and the counter holds.
  - Entering IR mode sets the manual cmd to STOP and clears the watchdog.
  - drive_cmd = manual cmd; drive_speed = manual speed, or 0 when STOP.
- mode_change is 1 in the same cycle that the registered mode or cam_state first shows a new value, and 0 otherwise. Back-to-back changes give back-to-back pulses.

Test Plan:
1. Reset deasserted, then ir_valid with 8'h0F -> next cycle mode=01, cam_state=00, drive_cmd=RIGHT (010), speed 0, mode_change=1 for exactly 1 cycle.
2. In CAM/SEARCH with SWEEP_CYCLES=8, no target -> search_dir toggles every 8 cycles, drive_cmd alternates 010/001.
3. In FOLLOW, cam_direction=11, cam_speed=2 -> FWD with speed 2. Then cam_direction=01, target dropped (LOST_TIMEOUT=5) -> LOST with STOP, and SEARCH after 5 cycles with search_dir=0. Re-acquire at cycle 3 of LOST -> back to FOLLOW.
4. ir_valid with 8'h0F and target_detected=1 in the same cycle from IDLE -> cam_state SEARCH, not FOLLOW. Then ir_valid with 8'h13 -> mode=10, cam_state=11, drive STOP.
5. IR mode: SPDUP x5 with SPEED_W=2 -> speed saturates at 3. Then FWD, then no ir_valid for IR_TIMEOUT=10 -> drive_cmd STOP after 10 cycles.
6. Assert reset mid-FOLLOW -> all outputs return to their reset values immediately, without waiting for a clock edge.
